// File: rtl/avr_harness_pkg.sv
// Shared definitions for the AVR program-memory harness: FSM encoding,
// default idle word and fetch-latency limits.
package avr_harness_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD    = 2'd0;
    localparam state_t ST_RELEASE = 2'd1;
    localparam state_t ST_RUN     = 2'd2;

    localparam logic [15:0] IDLE_WORD_DEF = 16'h0000;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 3;

    // Out-of-range latencies are pinned to the nearest legal value.
    function automatic int lat_clamp(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/avr_trace_fifo.sv
// Synchronous FIFO holding fetch trace entries, with a sticky overflow flag
// raised when a push finds the FIFO full and no pop in the same cycle.
module avr_trace_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] rdata_o,
    output logic         overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;

    logic full, empty, pop_ok, push_ok, drop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop_i && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop    = push_i && full && !pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) mem[wptr_q] <= wdata_i;
    end

    assign valid_o    = !empty;
    assign rdata_o    = mem[rptr_q];
    assign overflow_o = ovf_q;

endmodule

// File: rtl/avr_pmem_harness.sv
// Loadable instruction RAM for avr_core: holds the core in reset while loaded,
// serves fetches through a fixed-latency pipeline and traces every fetch.
module avr_pmem_harness
    import avr_harness_pkg::*;
#(
    parameter int          PA_W        = 9,
    parameter int          LATENCY     = 1,
    parameter int          TRACE_DEPTH = 16,
    parameter int          RST_HOLD    = 4,
    parameter logic [15:0] IDLE_WORD   = IDLE_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            core_rst,
    input  logic            pmem_ce,
    input  logic [PA_W-1:0] pmem_a,
    output logic [15:0]     pmem_d,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [PA_W-1:0] ld_addr,
    input  logic [15:0]     ld_data,
    input  logic            start,
    input  logic            stop,
    output logic            tr_valid,
    input  logic            tr_ready,
    output logic [PA_W-1:0] tr_addr,
    output logic [15:0]     tr_data,
    output logic            tr_overflow,
    output logic            running,
    output state_t          dbg_state
);

    localparam int LAT = lat_clamp(LATENCY);
    localparam int HW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int EW  = PA_W + 16;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          in_run, run_next;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_LOAD: begin
                if (start) begin
                    state_d = ST_RELEASE;
                    hold_d  = HW'(RST_HOLD - 1);
                end
            end
            ST_RELEASE: begin
                if (hold_q == '0) state_d = ST_RUN;
                else              hold_d  = hold_q - HW'(1);
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_LOAD;
        endcase
        if (stop) state_d = ST_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign in_run   = (state_q == ST_RUN);
    assign run_next = (state_d == ST_RUN);

    logic [15:0] mem [2**PA_W];
    logic [15:0] rd_word;

    always_ff @(posedge clk) begin
        if (ld_valid && ld_ready) mem[ld_addr] <= ld_data;
    end

    assign rd_word = mem[pmem_a];

    // Stage LAT-1 mirrors what pmem_d shows and feeds the trace FIFO.
    logic [LAT-1:0]  vld_q, in_vld;
    logic [PA_W-1:0] tag_q [LAT];
    logic [PA_W-1:0] in_tag [LAT];
    logic [15:0]     wrd_q [LAT];
    logic [15:0]     in_wrd [LAT];
    logic [15:0]     pmem_d_q;

    always_comb begin
        in_vld    = '0;
        in_vld[0] = in_run && pmem_ce;
        in_tag[0] = pmem_a;
        in_wrd[0] = rd_word;
        for (int i = 1; i < LAT; i++) begin
            in_vld[i] = vld_q[i-1];
            in_tag[i] = tag_q[i-1];
            in_wrd[i] = wrd_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            pmem_d_q <= IDLE_WORD;
        end else if (!run_next) begin
            vld_q    <= '0;
            pmem_d_q <= IDLE_WORD;
        end else begin
            vld_q <= in_vld;
            if (in_vld[LAT-1]) pmem_d_q <= in_wrd[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= in_tag[i];
            wrd_q[i] <= in_wrd[i];
        end
    end

    logic          tr_push;
    logic [EW-1:0] tr_wdata, tr_rdata;

    assign tr_push  = in_run && vld_q[LAT-1];
    assign tr_wdata = {tag_q[LAT-1], wrd_q[LAT-1]};

    avr_trace_fifo #(
        .W     (EW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (stop),
        .push_i     (tr_push),
        .wdata_i    (tr_wdata),
        .pop_i      (tr_ready),
        .valid_o    (tr_valid),
        .rdata_o    (tr_rdata),
        .overflow_o (tr_overflow)
    );

    assign core_rst  = !in_run;
    assign ld_ready  = (state_q == ST_LOAD);
    assign running   = in_run;
    assign pmem_d    = pmem_d_q;
    assign tr_addr   = tr_rdata[EW-1:16];
    assign tr_data   = tr_rdata[15:0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_avr_pmem_harness.sv
// Directed bench: instance a uses LATENCY=1/depth 16, instance b uses
// LATENCY=3/depth 4; both share loader, control and fetch inputs.
module tb_avr_pmem_harness;
    import avr_harness_pkg::*;

    logic        clk, rst_n;
    logic        pmem_ce, ld_valid, start, stop;
    logic [8:0]  pmem_a, ld_addr;
    logic [15:0] ld_data;
    logic        tr_ready_a, tr_ready_b;

    logic        core_rst_a, ld_ready_a, tr_valid_a, tr_ovf_a, running_a;
    logic [15:0] pmem_d_a, tr_data_a;
    logic [8:0]  tr_addr_a;
    state_t      state_a;
    logic        core_rst_b, ld_ready_b, tr_valid_b, tr_ovf_b, running_b;
    logic [15:0] pmem_d_b, tr_data_b;
    logic [8:0]  tr_addr_b;
    state_t      state_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [24:0] exp_q[$];

    avr_pmem_harness u_a (
        .clk(clk), .rst_n(rst_n), .core_rst(core_rst_a), .pmem_ce(pmem_ce),
        .pmem_a(pmem_a), .pmem_d(pmem_d_a), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .stop(stop),
        .tr_valid(tr_valid_a), .tr_ready(tr_ready_a), .tr_addr(tr_addr_a),
        .tr_data(tr_data_a), .tr_overflow(tr_ovf_a), .running(running_a),
        .dbg_state(state_a)
    );

    avr_pmem_harness #(.LATENCY(3), .TRACE_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .core_rst(core_rst_b), .pmem_ce(pmem_ce),
        .pmem_a(pmem_a), .pmem_d(pmem_d_b), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .stop(stop),
        .tr_valid(tr_valid_b), .tr_ready(tr_ready_b), .tr_addr(tr_addr_b),
        .tr_data(tr_data_b), .tr_overflow(tr_ovf_b), .running(running_b),
        .dbg_state(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [8:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic fetch(input logic [8:0] a);
        pmem_ce = 1'b1;
        pmem_a  = a;
        tick();
        pmem_ce = 1'b0;
    endtask

    task automatic restart();
        stop = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !running_a; i++) tick();
        chk("restart_running", running_a, 1);
    endtask

    // Pops the selected trace FIFO against exp_q until empty.
    task automatic drain(input bit sel_b, input int exp_n);
        int n;
        logic [24:0] e;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (!(sel_b ? tr_valid_b : tr_valid_a)) break;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1ffffff;
            chk("tr_addr", sel_b ? tr_addr_b : tr_addr_a, e[24:16]);
            chk("tr_data", sel_b ? tr_data_b : tr_data_a, e[15:0]);
            if (sel_b) tr_ready_b = 1'b1; else tr_ready_a = 1'b1;
            tick();
            tr_ready_a = 1'b0;
            tr_ready_b = 1'b0;
            n++;
        end
        chk("tr_count", n, exp_n);
        exp_q.delete();
    endtask

    initial begin
        int hold_cnt;
        rst_n = 1'b0; pmem_ce = 1'b0; pmem_a = '0; ld_valid = 1'b0;
        ld_addr = '0; ld_data = '0; start = 1'b0; stop = 1'b0;
        tr_ready_a = 1'b0; tr_ready_b = 1'b0;
        tick(); tick();
        chk("rst_core_rst", core_rst_a, 1);
        chk("rst_ld_ready", ld_ready_a, 1);
        chk("rst_pmem_d", pmem_d_a, 16'h0000);
        chk("rst_tr_valid", tr_valid_a, 0);
        chk("rst_tr_ovf", tr_ovf_a, 0);
        chk("rst_running", running_a, 0);
        chk("rst_state", state_a, ST_LOAD);
        rst_n = 1'b1;
        tick();

        // 1: load, release timing, LATENCY=1 fetch and trace
        load(9'h000, 16'hc00f);
        load(9'h001, 16'h1111);
        load(9'h002, 16'h2222);
        load(9'h010, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_ready_release", ld_ready_a, 0);
        hold_cnt = 0;
        for (int i = 0; i < 20 && core_rst_a; i++) begin
            hold_cnt++;
            tick();
        end
        chk("core_rst_hold", hold_cnt, 4);
        chk("running_a", running_a, 1);
        fetch(9'h000);
        chk("a_fetch0", pmem_d_a, 16'hc00f);
        fetch(9'h010);
        chk("a_fetch10", pmem_d_a, 16'h0000);
        tick(); tick();
        exp_q.push_back({9'h000, 16'hc00f});
        exp_q.push_back({9'h010, 16'h0000});
        drain(1'b0, 2);

        // 2: LATENCY=3 pipeline with one bubble
        restart();
        pmem_ce = 1'b1;
        pmem_a = 9'h000; tick();
        pmem_a = 9'h001; tick();
        pmem_a = 9'h002; tick();
        chk("b_lat_p3", pmem_d_b, 16'hc00f);
        pmem_ce = 1'b0; tick();
        chk("b_lat_p4", pmem_d_b, 16'h1111);
        pmem_ce = 1'b1; pmem_a = 9'h001; tick();
        chk("b_lat_p5", pmem_d_b, 16'h2222);
        pmem_ce = 1'b0; tick();
        chk("b_hold", pmem_d_b, 16'h2222);
        tick();
        chk("b_after_gap", pmem_d_b, 16'h1111);
        tick();
        chk("b_full_valid", tr_valid_b, 1);
        chk("b_full_no_ovf", tr_ovf_b, 0);

        // 4: full FIFO, push and pop in the same cycle
        exp_q.push_back({9'h000, 16'hc00f});
        exp_q.push_back({9'h001, 16'h1111});
        exp_q.push_back({9'h002, 16'h2222});
        exp_q.push_back({9'h001, 16'h1111});
        fetch(9'h000);
        tick(); tick();
        chk("b_head_before_pp", tr_data_b, 16'hc00f);
        tr_ready_b = 1'b1;
        tick();
        tr_ready_b = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({9'h000, 16'hc00f});
        chk("b_pp_no_ovf", tr_ovf_b, 0);
        drain(1'b1, 4);

        // 3: overflow with depth 4, then stop clears it
        restart();
        fetch(9'h000); fetch(9'h001); fetch(9'h002);
        fetch(9'h010); fetch(9'h000); fetch(9'h001);
        tick(); tick(); tick(); tick();
        chk("b_ovf_set", tr_ovf_b, 1);
        exp_q.push_back({9'h000, 16'hc00f});
        exp_q.push_back({9'h001, 16'h1111});
        exp_q.push_back({9'h002, 16'h2222});
        exp_q.push_back({9'h010, 16'h0000});
        drain(1'b1, 4);
        chk("b_ovf_sticky", tr_ovf_b, 1);
        fetch(9'h000);
        tick(); tick(); tick();
        chk("b_valid_before_stop", tr_valid_b, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("b_stop_valid", tr_valid_b, 0);
        chk("b_stop_ovf", tr_ovf_b, 0);
        chk("b_stop_pmem_d", pmem_d_b, 16'h0000);

        // 5: loader ignored in RUN; stop wins over start
        restart();
        chk("run_ld_ready", ld_ready_a, 0);
        load(9'h000, 16'hbeef);
        fetch(9'h000);
        chk("run_ld_ignored", pmem_d_a, 16'hc00f);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stop_start_state", state_a, ST_LOAD);
        chk("stop_start_pmem_d", pmem_d_a, 16'h0000);
        tick();
        chk("stop_start_hold", state_a, ST_LOAD);
        chk("stop_start_core_rst", core_rst_a, 1);

        // 6: asynchronous reset mid-RUN
        restart();
        fetch(9'h000);
        tick(); tick();
        chk("pre_rst_valid", tr_valid_a, 1);
        chk("pre_rst_pmem_d", pmem_d_a, 16'hc00f);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_core_rst", core_rst_a, 1);
        chk("arst_pmem_d", pmem_d_a, 16'h0000);
        chk("arst_tr_valid", tr_valid_a, 0);
        chk("arst_running", running_a, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
